result_pair_aligner: RTL and testbench

- Sits directly upstream of the scoreboard in the verification platform controller.
- Collects golden ciphertext blocks from the reference model (expected stream) and ciphertext blocks from the AES-128 DUT (actual stream).
- Buffers each stream in its own FIFO and presents in-order expected/actual pairs to the scoreboard, with a match flag and sequence index.
- Absorbs latency skew between the model and the DUT.

---
 rtl/result_pair_aligner.sv | 153 +++++++++++++++
 tb/tb_result_pair_aligner.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_pair_aligner.sv
// Pairs the golden (expected) and DUT (actual) ciphertext streams in arrival order,
// absorbing latency skew in two FIFOs and presenting one registered pair at a time.
module result_pair_aligner #(
  parameter int DW    = 128,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             exp_valid,
  output logic             exp_ready,
  input  logic [DW-1:0]    exp_data,
  input  logic             act_valid,
  input  logic [DW-1:0]    act_data,
  output logic             pair_valid,
  input  logic             pair_ready,
  output logic [DW-1:0]    pair_exp,
  output logic [DW-1:0]    pair_act,
  output logic             pair_match,
  output logic [CNT_W-1:0] pair_idx,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             act_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DW-1:0] exp_mem [DEPTH];
  logic [DW-1:0] act_mem [DEPTH];

  logic [AW:0]      exp_wr_q, exp_wr_d, exp_rd_q, exp_rd_d;
  logic [AW:0]      act_wr_q, act_wr_d, act_rd_q, act_rd_d;
  logic             pair_valid_q, pair_valid_d;
  logic [DW-1:0]    pair_exp_q, pair_exp_d;
  logic [DW-1:0]    pair_act_q, pair_act_d;
  logic             pair_match_q, pair_match_d;
  logic [CNT_W-1:0] pair_idx_q, pair_idx_d;
  logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;
  logic             act_ovf_q, act_ovf_d;

  logic          exp_full, exp_empty, act_full, act_empty;
  logic          exp_wr, act_wr, load, accept;
  logic [DW-1:0] exp_head, act_head;

  // Extra pointer MSB separates full (lower bits equal, MSB differs) from empty.
  assign exp_full  = (exp_wr_q[AW-1:0] == exp_rd_q[AW-1:0]) && (exp_wr_q[AW] != exp_rd_q[AW]);
  assign exp_empty = (exp_wr_q == exp_rd_q);
  assign act_full  = (act_wr_q[AW-1:0] == act_rd_q[AW-1:0]) && (act_wr_q[AW] != act_rd_q[AW]);
  assign act_empty = (act_wr_q == act_rd_q);

  assign exp_head = exp_mem[exp_rd_q[AW-1:0]];
  assign act_head = act_mem[act_rd_q[AW-1:0]];

  assign exp_ready = !exp_full;
  assign exp_wr    = exp_valid && !exp_full && !clr;
  assign act_wr    = act_valid && !act_full && !clr;
  assign accept    = pair_valid_q && pair_ready;
  assign load      = !exp_empty && !act_empty && (!pair_valid_q || pair_ready);

  always_ff @(posedge clk) begin
    if (exp_wr) exp_mem[exp_wr_q[AW-1:0]] <= exp_data;
    if (act_wr) act_mem[act_wr_q[AW-1:0]] <= act_data;
  end

  always_comb begin
    exp_wr_d       = exp_wr_q;
    exp_rd_d       = exp_rd_q;
    act_wr_d       = act_wr_q;
    act_rd_d       = act_rd_q;
    pair_valid_d   = pair_valid_q;
    pair_exp_d     = pair_exp_q;
    pair_act_d     = pair_act_q;
    pair_match_d   = pair_match_q;
    pair_idx_d     = pair_idx_q;
    mismatch_cnt_d = mismatch_cnt_q;
    act_ovf_d      = act_ovf_q;

    if (clr) begin
      exp_wr_d       = '0;
      exp_rd_d       = '0;
      act_wr_d       = '0;
      act_rd_d       = '0;
      pair_valid_d   = 1'b0;
      pair_exp_d     = '0;
      pair_act_d     = '0;
      pair_match_d   = 1'b0;
      pair_idx_d     = '0;
      mismatch_cnt_d = '0;
      act_ovf_d      = 1'b0;
    end else begin
      if (exp_wr) exp_wr_d = exp_wr_q + PTR_ONE;
      if (act_wr) act_wr_d = act_wr_q + PTR_ONE;
      if (act_valid && act_full) act_ovf_d = 1'b1;

      if (accept) begin
        pair_valid_d = 1'b0;
        pair_idx_d   = pair_idx_q + CNT_ONE;
        if (!pair_match_q && mismatch_cnt_q != CNT_MAX)
          mismatch_cnt_d = mismatch_cnt_q + CNT_ONE;
      end

      // Match is taken from the same heads that are captured, keeping flag and data coherent.
      if (load) begin
        exp_rd_d     = exp_rd_q + PTR_ONE;
        act_rd_d     = act_rd_q + PTR_ONE;
        pair_valid_d = 1'b1;
        pair_exp_d   = exp_head;
        pair_act_d   = act_head;
        pair_match_d = (exp_head == act_head);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_wr_q       <= '0;
      exp_rd_q       <= '0;
      act_wr_q       <= '0;
      act_rd_q       <= '0;
      pair_valid_q   <= 1'b0;
      pair_exp_q     <= '0;
      pair_act_q     <= '0;
      pair_match_q   <= 1'b0;
      pair_idx_q     <= '0;
      mismatch_cnt_q <= '0;
      act_ovf_q      <= 1'b0;
    end else begin
      exp_wr_q       <= exp_wr_d;
      exp_rd_q       <= exp_rd_d;
      act_wr_q       <= act_wr_d;
      act_rd_q       <= act_rd_d;
      pair_valid_q   <= pair_valid_d;
      pair_exp_q     <= pair_exp_d;
      pair_act_q     <= pair_act_d;
      pair_match_q   <= pair_match_d;
      pair_idx_q     <= pair_idx_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      act_ovf_q      <= act_ovf_d;
    end
  end

  assign pair_valid   = pair_valid_q;
  assign pair_exp     = pair_exp_q;
  assign pair_act     = pair_act_q;
  assign pair_match   = pair_match_q;
  assign pair_idx     = pair_idx_q;
  assign mismatch_cnt = mismatch_cnt_q;
  assign act_ovf      = act_ovf_q;

endmodule

// File: tb/tb_result_pair_aligner.sv
// Directed scenarios for result_pair_aligner; expected pairs go into a queue and a
// negedge monitor pops and compares each accepted pair.
module tb_result_pair_aligner;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         exp_valid = 1'b0;
  logic         exp_ready;
  logic [127:0] exp_data = '0;
  logic         act_valid = 1'b0;
  logic [127:0] act_data = '0;
  logic         pair_valid;
  logic         pair_ready = 1'b0;
  logic [127:0] pair_exp;
  logic [127:0] pair_act;
  logic         pair_match;
  logic [3:0]   pair_idx;
  logic [3:0]   mismatch_cnt;
  logic         act_ovf;

  int tests_run = 0;
  int fails = 0;

  typedef struct {
    logic [127:0] e;
    logic [127:0] a;
    logic         m;
    logic [3:0]   idx;
  } pair_t;
  pair_t sb[$];

  logic [127:0] blk [6];

  always #5 clk = ~clk;

  result_pair_aligner #(.DW(128), .DEPTH(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_data(exp_data),
    .act_valid(act_valid), .act_data(act_data),
    .pair_valid(pair_valid), .pair_ready(pair_ready),
    .pair_exp(pair_exp), .pair_act(pair_act), .pair_match(pair_match),
    .pair_idx(pair_idx), .mismatch_cnt(mismatch_cnt), .act_ovf(act_ovf)
  );

  // Monitor: every accepted pair must be the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && pair_valid && pair_ready) begin
      tests_run++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pair: got exp=%h act=%h idx=%0d, required none", pair_exp, pair_act, pair_idx);
      end else begin
        pair_t p;
        p = sb.pop_front();
        if (pair_exp !== p.e || pair_act !== p.a || pair_match !== p.m || pair_idx !== p.idx) begin
          fails++;
          $display("FAIL pair_%0d: got exp=%h act=%h m=%b idx=%0d, required exp=%h act=%h m=%b idx=%0d",
                   p.idx, pair_exp, pair_act, pair_match, pair_idx, p.e, p.a, p.m, p.idx);
        end else begin
          $display("[TB] pair idx=%0d exp=%h act=%h match=%b ok", pair_idx, pair_exp, pair_act, pair_match);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] req);
    tests_run++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end else begin
      $display("[TB] %s = %0h ok", name, got);
    end
  endtask

  task automatic push(input logic [127:0] e, input logic [127:0] a, input logic m, input logic [3:0] idx);
    pair_t p;
    p.e = e; p.a = a; p.m = m; p.idx = idx;
    sb.push_back(p);
  endtask

  // Holds exp_valid until the block is taken (bounded).
  task automatic send_exp(input logic [127:0] d, input int bound);
    bit ok;
    int n;
    n = 0;
    exp_valid = 1'b1;
    exp_data  = d;
    do begin
      @(negedge clk);
      ok = exp_ready;
      tick();
      n++;
    end while (!ok && n < bound);
    exp_valid = 1'b0;
    tests_run++;
    if (!ok) begin
      fails++;
      $display("FAIL send_exp_timeout: got no acceptance after %0d cycles, required acceptance", n);
    end
  endtask

  task automatic wait_drain(input string name, input int bound);
    int n;
    n = 0;
    while (sb.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    tests_run++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: got %0d pairs outstanding, required 0", name, sb.size());
      sb.delete();
    end
    repeat (2) tick();
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] v;
    for (int i = 0; i < 6; i++) blk[i] = {120'hA5A5_0000_1111, 8'(i)};

    // Reset state
    #3;
    chk("rst_pair_valid", {127'd0, pair_valid}, 128'd0);
    chk("rst_pair_idx", {124'd0, pair_idx}, 128'd0);
    chk("rst_mismatch_cnt", {124'd0, mismatch_cnt}, 128'd0);
    chk("rst_act_ovf", {127'd0, act_ovf}, 128'd0);
    chk("rst_pair_exp", pair_exp, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_exp_ready", {127'd0, exp_ready}, 128'd1);

    // Basic pairing: act blocks trail exp by 5 cycles
    pair_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(128'(i + 1), 128'(i + 1), 1'b1, 4'(i));
    for (int i = 0; i < 3; i++) begin
      exp_valid = 1'b1; exp_data = 128'(i + 1);
      tick();
    end
    exp_valid = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      act_valid = 1'b1; act_data = 128'(i + 1);
      tick();
    end
    act_valid = 1'b0;
    wait_drain("basic", 30);
    chk("basic_mismatch_cnt", {124'd0, mismatch_cnt}, 128'd0);
    chk("basic_act_ovf", {127'd0, act_ovf}, 128'd0);

    // Mismatch: bit 0 flipped
    v = 128'h3925841d02dc09fbdc118597196a0b32;
    push(v, v ^ 128'd1, 1'b0, 4'd3);
    exp_valid = 1'b1; exp_data = v; act_valid = 1'b1; act_data = v ^ 128'd1;
    tick();
    exp_valid = 1'b0; act_valid = 1'b0;
    wait_drain("mismatch", 30);
    chk("mismatch_cnt_after_one", {124'd0, mismatch_cnt}, 128'd1);

    // Back-pressure on the expected side
    pulse_clr();
    pair_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(blk[i], blk[i], 1'b1, 4'(i));
    act_valid = 1'b1; act_data = blk[0];
    send_exp(blk[0], 10);
    act_valid = 1'b0;
    chk("bp_valid_before_load", {127'd0, pair_valid}, 128'd0);
    send_exp(blk[1], 10);
    chk("bp_valid_after_load", {127'd0, pair_valid}, 128'd1);
    chk("bp_first_exp", pair_exp, blk[0]);
    for (int i = 2; i < 5; i++) send_exp(blk[i], 10);
    chk("bp_exp_ready_full", {127'd0, exp_ready}, 128'd0);
    exp_valid = 1'b1; exp_data = blk[5];
    repeat (3) tick();
    chk("bp_hold_exp_ready", {127'd0, exp_ready}, 128'd0);
    chk("bp_hold_pair_exp", pair_exp, blk[0]);
    chk("bp_hold_pair_act", pair_act, blk[0]);
    chk("bp_hold_pair_valid", {127'd0, pair_valid}, 128'd1);
    fork
      send_exp(blk[5], 40);
      begin
        pair_ready = 1'b1;
        for (int i = 1; i < 6; i++) begin
          act_valid = 1'b1; act_data = blk[i];
          tick();
        end
        act_valid = 1'b0;
      end
    join
    wait_drain("backpressure", 40);

    // Actual overflow: 6 act blocks against a stalled output
    pulse_clr();
    pair_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      act_valid = 1'b1; act_data = blk[i] ^ 128'hF0;
      exp_valid = (i == 0); exp_data = blk[0] ^ 128'hF0;
      tick();
      if (i == 4) chk("ovf_before_drop", {127'd0, act_ovf}, 128'd0);
    end
    act_valid = 1'b0; exp_valid = 1'b0;
    chk("ovf_set", {127'd0, act_ovf}, 128'd1);
    chk("ovf_stage_act", pair_act, blk[0] ^ 128'hF0);
    for (int i = 0; i < 5; i++) push(blk[i] ^ 128'hF0, blk[i] ^ 128'hF0, 1'b1, 4'(i));
    push(blk[5] ^ 128'hF0, 128'h0C0FFEE, 1'b0, 4'd5);
    pair_ready = 1'b1;
    for (int i = 1; i < 6; i++) send_exp(blk[i] ^ 128'hF0, 10);
    act_valid = 1'b1; act_data = 128'h0C0FFEE;
    tick();
    act_valid = 1'b0;
    wait_drain("overflow", 40);
    chk("ovf_mismatch_cnt", {124'd0, mismatch_cnt}, 128'd1);
    chk("ovf_sticky", {127'd0, act_ovf}, 128'd1);

    // Saturation and wrap with 4-bit counters
    pulse_clr();
    pair_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      v = {120'h5A, 8'(i)};
      push(v, ~v, 1'b0, 4'(i));
      exp_valid = 1'b1; exp_data = v; act_valid = 1'b1; act_data = ~v;
      tick();
    end
    exp_valid = 1'b0; act_valid = 1'b0;
    wait_drain("saturate", 40);
    chk("sat_mismatch_cnt", {124'd0, mismatch_cnt}, 128'd15);
    chk("wrap_pair_idx", {124'd0, pair_idx}, 128'd1);

    // Clear mid-operation
    pair_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      act_valid = 1'b1; act_data = blk[i];
      exp_valid = (i < 3); exp_data = blk[i] ^ 128'h3;
      tick();
    end
    act_valid = 1'b0; exp_valid = 1'b0;
    chk("clr_pre_valid", {127'd0, pair_valid}, 128'd1);
    chk("clr_pre_ovf", {127'd0, act_ovf}, 128'd1);
    pulse_clr();
    chk("clr_pair_valid", {127'd0, pair_valid}, 128'd0);
    chk("clr_pair_idx", {124'd0, pair_idx}, 128'd0);
    chk("clr_mismatch_cnt", {124'd0, mismatch_cnt}, 128'd0);
    chk("clr_act_ovf", {127'd0, act_ovf}, 128'd0);
    chk("clr_pair_exp", pair_exp, 128'd0);
    chk("clr_exp_ready", {127'd0, exp_ready}, 128'd1);
    pair_ready = 1'b1;
    repeat (3) tick();
    chk("clr_fifos_empty", {127'd0, pair_valid}, 128'd0);
    push(128'hBEEF, 128'hBEEF, 1'b1, 4'd0);
    exp_valid = 1'b1; exp_data = 128'hBEEF; act_valid = 1'b1; act_data = 128'hBEEF;
    tick();
    exp_valid = 1'b0; act_valid = 1'b0;
    wait_drain("after_clr", 20);

    // Asynchronous reset mid-operation
    push(128'h1234, 128'h1235, 1'b0, 4'd1);
    exp_valid = 1'b1; exp_data = 128'h1234; act_valid = 1'b1; act_data = 128'h1235;
    tick();
    exp_valid = 1'b0; act_valid = 1'b0;
    wait_drain("pre_rst", 20);
    pair_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      act_valid = 1'b1; act_data = blk[i];
      exp_valid = (i < 2); exp_data = blk[i];
      tick();
    end
    act_valid = 1'b0; exp_valid = 1'b0;
    chk("rst_pre_mismatch", {124'd0, mismatch_cnt}, 128'd1);
    chk("rst_pre_valid", {127'd0, pair_valid}, 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pair_valid", {127'd0, pair_valid}, 128'd0);
    chk("arst_pair_idx", {124'd0, pair_idx}, 128'd0);
    chk("arst_mismatch_cnt", {124'd0, mismatch_cnt}, 128'd0);
    chk("arst_act_ovf", {127'd0, act_ovf}, 128'd0);
    chk("arst_pair_act", pair_act, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("arst_exp_ready", {127'd0, exp_ready}, 128'd1);
    pair_ready = 1'b1;
    repeat (3) tick();
    chk("arst_fifos_empty", {127'd0, pair_valid}, 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
